// File: rtl/reg_write_decoder_seq_if.sv
// Write-port bundle for reg_write_decoder_seq: write request and clear request in,
// registered one-hot enables and sweep status out.
interface reg_write_decoder_seq_if #(
    parameter int unsigned SEL_WIDTH = 5,
    parameter int unsigned NUM_REGS  = 32
);
    logic                 write_en;
    logic [SEL_WIDTH-1:0] select;
    logic                 clear_req;
    logic [NUM_REGS-1:0]  out;
    logic [SEL_WIDTH-1:0] out_select;
    logic                 clear_busy;
    logic                 clear_done;
    logic                 illegal_sel;

    modport master (
        output write_en, select, clear_req,
        input  out, out_select, clear_busy, clear_done, illegal_sel
    );

    modport slave (
        input  write_en, select, clear_req,
        output out, out_select, clear_busy, clear_done, illegal_sel
    );
endinterface

// File: rtl/reg_write_decoder_seq.sv
// Registered one-hot write-enable decoder with a register-file clear sweep.
// Optional build macro REG_ZERO_MASK_EN: masks out[ZERO_REG] in every mode.
module reg_write_decoder_seq #(
    parameter int unsigned SEL_WIDTH = 5,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ZERO_REG  = 31
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    reg_write_decoder_seq_if.slave bus
);
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_SWEEP = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE  = 2'd2;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);
`ifdef REG_ZERO_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif
    localparam logic [NUM_REGS-1:0] ZERO_MASK = MASK_EN ? (NUM_REGS'(1) << ZERO_REG) : '0;

    logic [STATE_W-1:0]   r_state, w_state_nxt;
    logic [SEL_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [NUM_REGS-1:0]  r_out, w_out_nxt;
    logic [SEL_WIDTH-1:0] r_out_sel, w_out_sel_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_illegal, w_illegal_nxt;
    logic                 w_sel_legal;

    // One-hot decode with the hardwired-zero register masked off.
    function automatic logic [NUM_REGS-1:0] f_onehot(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            v[i] = (idx == SEL_WIDTH'(i));
        end
        return v & ~ZERO_MASK;
    endfunction

    assign w_sel_legal = (32'(bus.select) < NUM_REGS);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_out_nxt     = '0;
        w_out_sel_nxt = r_out_sel;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.write_en) begin
                    if (w_sel_legal) begin
                        w_out_nxt     = f_onehot(bus.select);
                        w_out_sel_nxt = bus.select;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
                if (bus.clear_req) begin
                    w_state_nxt = S_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            S_SWEEP: begin
                // Counter may wrap to 0 here; only LAST_IDX leaves the sweep.
                w_out_nxt     = f_onehot(r_cnt);
                w_out_sel_nxt = r_cnt;
                w_busy_nxt    = 1'b1;
                w_cnt_nxt     = r_cnt + SEL_WIDTH'(1);
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_out     <= '0;
            r_out_sel <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out     <= w_out_nxt;
            r_out_sel <= w_out_sel_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign bus.out         = r_out;
    assign bus.out_select  = r_out_sel;
    assign bus.clear_busy  = r_busy;
    assign bus.clear_done  = r_done;
    assign bus.illegal_sel = r_illegal;
endmodule

// File: tb/tb_reg_write_decoder_seq.sv
// Self-checking bench for reg_write_decoder_seq: a full-width instance (32 regs) and a
// partial instance (24 regs) driven in lockstep and compared against a sweep-position model.
`timescale 1ns/1ps
module tb_reg_write_decoder_seq;
    localparam int SW = 5;
    localparam int NA = 32;
    localparam int NB = 24;
    localparam int ZA = 31;
    localparam int ZB = 23;
`ifdef REG_ZERO_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] out;
        logic [4:0]  osel;
        logic        busy;
        logic        done;
        logic        ill;
    } obs_t;

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [31:0] eo;
        logic [4:0]  es;
        logic        ei;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [4:0] sel = '0;
    logic       clr = 1'b0;

    int errs   = 0;
    int checks = 0;

    int   m_swp[2];
    logic [4:0] m_sel[2];
    obs_t m_exp[2];

    always #5 clk = ~clk;

    reg_write_decoder_seq_if #(.SEL_WIDTH(SW), .NUM_REGS(NA)) bus_a ();
    reg_write_decoder_seq_if #(.SEL_WIDTH(SW), .NUM_REGS(NB)) bus_b ();

    assign bus_a.write_en  = we;
    assign bus_a.select    = sel;
    assign bus_a.clear_req = clr;
    assign bus_b.write_en  = we;
    assign bus_b.select    = sel;
    assign bus_b.clear_req = clr;

    reg_write_decoder_seq #(.SEL_WIDTH(SW), .NUM_REGS(NA), .ZERO_REG(ZA)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a.slave)
    );
    reg_write_decoder_seq #(.SEL_WIDTH(SW), .NUM_REGS(NB), .ZERO_REG(ZB)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b.slave)
    );

    function automatic logic [31:0] exp_onehot(int i, int idx);
        int zr;
        zr = (i == 0) ? ZA : ZB;
        if (MASK_EN && idx == zr) return 32'd0;
        return 32'd1 << idx;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_swp[i] = -1;
            m_sel[i] = '0;
            m_exp[i] = '0;
        end
    endfunction

    // m_swp: -1 idle, 0..n-1 next register to sweep, n means the done pulse is next.
    function automatic void model_step(int i);
        int   n;
        obs_t e;
        n = (i == 0) ? NA : NB;
        e = '0;
        e.osel = m_sel[i];
        if (m_swp[i] < 0) begin
            if (we) begin
                if (int'(sel) < n) begin
                    e.out  = exp_onehot(i, int'(sel));
                    e.osel = sel;
                end else begin
                    e.ill = 1'b1;
                end
            end
            if (clr) m_swp[i] = 0;
        end else if (m_swp[i] < n) begin
            e.out  = exp_onehot(i, m_swp[i]);
            e.osel = 5'(m_swp[i]);
            e.busy = 1'b1;
            m_swp[i]++;
        end else begin
            e.done   = 1'b1;
            m_swp[i] = -1;
        end
        m_sel[i] = e.osel;
        m_exp[i] = e;
    endfunction

    function automatic obs_t act(int i);
        obs_t a;
        if (i == 0) begin
            a.out  = bus_a.out;
            a.osel = bus_a.out_select;
            a.busy = bus_a.clear_busy;
            a.done = bus_a.clear_done;
            a.ill  = bus_a.illegal_sel;
        end else begin
            a.out  = 32'(bus_b.out);
            a.osel = bus_b.out_select;
            a.busy = bus_b.clear_busy;
            a.done = bus_b.clear_done;
            a.ill  = bus_b.illegal_sel;
        end
        return a;
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic cmp_model(int i);
        obs_t  a;
        obs_t  e;
        string t;
        a = act(i);
        e = m_exp[i];
        t = (i == 0) ? "a" : "b";
        chk($sformatf("%s_out", t), a.out, e.out);
        chk($sformatf("%s_out_select", t), 32'(a.osel), 32'(e.osel));
        chk($sformatf("%s_clear_busy", t), 32'(a.busy), 32'(e.busy));
        chk($sformatf("%s_clear_done", t), 32'(a.done), 32'(e.done));
        chk($sformatf("%s_illegal_sel", t), 32'(a.ill), 32'(e.ill));
        chk($sformatf("%s_onehot", t), 32'($countones(a.out) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp_model(0);
        cmp_model(1);
    endtask

    vec_t vt[$];

    initial begin
        // Directed vectors for the 32-register instance, starting from out_select=0.
        vt.push_back('{1'b1, 5'd5,  exp_onehot(0, 5),  5'd5,  1'b0});
        vt.push_back('{1'b0, 5'd9,  32'd0,             5'd5,  1'b0});
        vt.push_back('{1'b1, 5'd0,  exp_onehot(0, 0),  5'd0,  1'b0});
        vt.push_back('{1'b1, 5'd16, exp_onehot(0, 16), 5'd16, 1'b0});
        vt.push_back('{1'b0, 5'd3,  32'd0,             5'd16, 1'b0});
        for (int k = 0; k < 32; k++) begin
            vt.push_back('{1'b1, 5'(k), exp_onehot(0, k), 5'(k), 1'b0});
        end
        vt.push_back('{1'b0, 5'd7, 32'd0, 5'd31, 1'b0});

        model_reset();
        #12;
        cmp_model(0);
        cmp_model(1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[j]) begin
            we  = vt[j].we;
            sel = vt[j].sel;
            clr = 1'b0;
            step();
            chk($sformatf("vec%0d_out", j), bus_a.out, vt[j].eo);
            chk($sformatf("vec%0d_out_select", j), 32'(bus_a.out_select), 32'(vt[j].es));
            chk($sformatf("vec%0d_illegal", j), 32'(bus_a.illegal_sel), 32'(vt[j].ei));
        end

        // Out-of-range select on the 24-register instance pulses illegal_sel once.
        we = 1'b1; sel = 5'd27;
        step();
        chk("b_sel27_illegal", 32'(bus_b.illegal_sel), 32'd1);
        chk("b_sel27_out", 32'(bus_b.out), 32'd0);
        we = 1'b0;
        step();
        chk("b_illegal_one_cycle", 32'(bus_b.illegal_sel), 32'd0);

        // Clear request alongside a write: write decodes first, then the sweep.
        we = 1'b1; sel = 5'd3; clr = 1'b1;
        step();
        chk("sweep_entry_write", bus_a.out, exp_onehot(0, 3));
        chk("sweep_entry_not_busy", 32'(bus_a.clear_busy), 32'd0);
        for (int k = 0; k < NA; k++) begin
            sel = 5'($urandom_range(0, 31));
            step();
            chk($sformatf("sweep_k%0d_out", k), bus_a.out, exp_onehot(0, k));
            chk($sformatf("sweep_k%0d_sel", k), 32'(bus_a.out_select), 32'(k));
            chk($sformatf("sweep_k%0d_busy", k), 32'(bus_a.clear_busy), 32'd1);
        end
        step();
        chk("sweep_done_pulse", 32'(bus_a.clear_done), 32'd1);
        chk("sweep_done_out", bus_a.out, 32'd0);
        chk("sweep_done_busy", 32'(bus_a.clear_busy), 32'd0);
        we = 1'b0; clr = 1'b0;
        step();
        chk("after_done_no_resweep", 32'(bus_a.clear_busy), 32'd0);
        chk("after_done_pulse_gone", 32'(bus_a.clear_done), 32'd0);

        // Reset in the middle of a sweep aborts it without a done pulse.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (11) step();
        chk("pre_reset_k10", bus_a.out, exp_onehot(0, 10));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        cmp_model(0);
        cmp_model(1);
        @(posedge clk);
        #1;
        cmp_model(0);
        cmp_model(1);
        chk("reset_no_done", 32'(bus_a.clear_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("restart_k0_out", bus_a.out, exp_onehot(0, 0));
        chk("restart_k0_busy", 32'(bus_a.clear_busy), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            we  = ($urandom_range(0, 3) != 0);
            sel = 5'($urandom_range(0, 31));
            clr = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
